// File: rtl/scoreboard_bcd_counter_if.sv
// Bundle of the score counter's control inputs and display/count outputs.
// Handshake: there is no ready; a rising edge of i_tick while i_en is high is the only "valid", and it is always accepted.
interface scoreboard_bcd_counter_if;
    logic       i_tick;
    logic       i_en;
    logic       i_up;
    logic       i_clr;
    logic [3:0] tens_o;
    logic [3:0] ones_o;
    logic       tc_o;
    logic [3:0] an_o;
    logic [6:0] seg_o;

    modport master (
        output i_tick, i_en, i_up, i_clr,
        input  tens_o, ones_o, tc_o, an_o, seg_o
    );

    modport slave (
        input  i_tick, i_en, i_up, i_clr,
        output tens_o, ones_o, tc_o, an_o, seg_o
    );
endinterface

// File: rtl/scoreboard_bcd_counter.sv
// Two-digit BCD up/down score counter stepped by tick rising edges,
// with a two-digit time-multiplexed active-low 7-segment driver.
module scoreboard_bcd_counter #(
    parameter int WRAP          = 1,
    parameter int REFRESH_COUNT = 100_000,
    parameter int REFRESH_WIDTH = 17
) (
    input logic                   i_clk,
    input logic                   i_rst,
    scoreboard_bcd_counter_if.slave bus
);

    localparam logic [REFRESH_WIDTH-1:0] REFRESH_LAST = REFRESH_WIDTH'(REFRESH_COUNT - 1);

    logic                     tick_q;
    logic [3:0]               tens;
    logic [3:0]               ones;
    logic                     tc;
    logic [REFRESH_WIDTH-1:0] refresh_cnt;
    logic                     sel;
    logic [6:0]               seg;
    logic                     step;
    logic [3:0]               digit;
    logic [6:0]               seg_next;

    assign step = bus.i_tick & ~tick_q & bus.i_en;

    // Count state; tick_q resets high so a tick already high at release is not an edge.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            tick_q <= 1'b1;
            tens   <= 4'd0;
            ones   <= 4'd0;
            tc     <= 1'b0;
        end else begin
            tick_q <= bus.i_tick;
            tc     <= 1'b0;
            if (bus.i_clr) begin
                tens <= 4'd0;
                ones <= 4'd0;
            end else if (step) begin
                if (bus.i_up) begin
                    if (tens == 4'd9 && ones == 4'd9) begin
                        tc <= 1'b1;
                        if (WRAP != 0) begin
                            tens <= 4'd0;
                            ones <= 4'd0;
                        end
                    end else if (ones == 4'd9) begin
                        ones <= 4'd0;
                        tens <= tens + 4'd1;
                    end else begin
                        ones <= ones + 4'd1;
                    end
                end else begin
                    if (tens == 4'd0 && ones == 4'd0) begin
                        tc <= 1'b1;
                        if (WRAP != 0) begin
                            tens <= 4'd9;
                            ones <= 4'd9;
                        end
                    end else if (ones == 4'd0) begin
                        ones <= 4'd9;
                        tens <= tens - 4'd1;
                    end else begin
                        ones <= ones - 4'd1;
                    end
                end
            end
        end
    end

    always_comb begin
        digit = sel ? tens : ones;
        case (digit)
            4'd0:    seg_next = 7'b1000000;
            4'd1:    seg_next = 7'b1111001;
            4'd2:    seg_next = 7'b0100100;
            4'd3:    seg_next = 7'b0110000;
            4'd4:    seg_next = 7'b0011001;
            4'd5:    seg_next = 7'b0010010;
            4'd6:    seg_next = 7'b0000010;
            4'd7:    seg_next = 7'b1111000;
            4'd8:    seg_next = 7'b0000000;
            4'd9:    seg_next = 7'b0010000;
            default: seg_next = 7'b1111111;
        endcase
    end

    // Display refresh runs freely; enable and clear do not touch it.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            refresh_cnt <= '0;
            sel         <= 1'b0;
            seg         <= 7'b1000000;
        end else begin
            seg <= seg_next;
            if (refresh_cnt == REFRESH_LAST) begin
                refresh_cnt <= '0;
                sel         <= ~sel;
            end else begin
                refresh_cnt <= refresh_cnt + 1'b1;
            end
        end
    end

    assign bus.tens_o = tens;
    assign bus.ones_o = ones;
    assign bus.tc_o   = tc;
    assign bus.an_o   = sel ? 4'b1101 : 4'b1110;
    assign bus.seg_o  = seg;

endmodule
